arc4_prga: RTL and testbench

- Pseudo-random generation stage of the ARC4 decrypt pipeline, directly downstream of the key-scheduling stage.
- Takes the scheduled 256-byte state array S, reads the length-prefixed ciphertext CT, and writes the length-prefixed plaintext PT.
- It is enabled only after the key-scheduling stage reports rdy.
- Shares the S memory port with that stage; the top-level controller muxes S-port ownership.

---
 rtl/arc4_pkg.sv | 25 ++
 rtl/arc4_prga.sv | 154 +++++++++++++++
 tb/tb_arc4_prga.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/arc4_pkg.sv
// Shared ARC4 pipeline package: FSM states and constants used by the
// init, key-scheduling and pseudo-random generation stages.
package arc4_pkg;

  localparam int          S_SIZE    = 256;
  localparam logic [7:0]  ASCII_MIN = 8'h20;
  localparam logic [7:0]  ASCII_MAX = 8'h7E;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_LEN,
    ST_WR_LEN,
    ST_RD_I,
    ST_RD_J,
    ST_WR_I,
    ST_WR_J,
    ST_RD_K,
    ST_WR_PT
  } prga_st_e;

  function automatic logic is_print(input logic [7:0] b);
    return (b >= ASCII_MIN) && (b <= ASCII_MAX);
  endfunction

endpackage

// File: rtl/arc4_prga.sv
// ARC4 pseudo-random generation stage: XORs the keystream from S into
// length-prefixed CT and writes length-prefixed PT.
// Ports: clk, rst_n (async low), en/rdy handshake, S port
// (s_addr/s_rddata/s_wrdata/s_wren), CT read port (ct_addr/ct_rddata),
// PT write port (pt_addr/pt_wrdata/pt_wren). All memories have 1-cycle
// synchronous read latency.
// Macro ARC4_PRGA_ASCII_CHECK_EN adds pt_ok: cleared when any output
// byte of the run falls outside 0x20..0x7E.
module arc4_prga
  import arc4_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] s_addr,
  input  logic [7:0] s_rddata,
  output logic [7:0] s_wrdata,
  output logic       s_wren,
  output logic [7:0] ct_addr,
  input  logic [7:0] ct_rddata,
  output logic [7:0] pt_addr,
  output logic [7:0] pt_wrdata,
  output logic       pt_wren
`ifdef ARC4_PRGA_ASCII_CHECK_EN
  ,
  output logic       pt_ok
`endif
);

  prga_st_e   state_q, state_d;
  logic [7:0] i_q, i_d;
  logic [7:0] j_q, j_d;
  logic [7:0] k_q, k_d;
  logic [7:0] len_q, len_d;
  logic [7:0] si_q, si_d;
  logic [7:0] sj_q, sj_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      len_q   <= '0;
      si_q    <= '0;
      sj_q    <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      len_q   <= len_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    k_d       = k_q;
    len_d     = len_q;
    si_d      = si_q;
    sj_d      = sj_q;
    s_addr    = '0;
    s_wrdata  = '0;
    s_wren    = 1'b0;
    ct_addr   = '0;
    pt_addr   = '0;
    pt_wrdata = '0;
    pt_wren   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en) state_d = ST_RD_LEN;
      end
      ST_RD_LEN: begin
        ct_addr = 8'd0;
        state_d = ST_WR_LEN;
      end
      ST_WR_LEN: begin
        len_d     = ct_rddata;
        pt_addr   = 8'd0;
        pt_wrdata = ct_rddata;
        pt_wren   = 1'b1;
        i_d       = 8'd0;
        j_d       = 8'd0;
        k_d       = 8'd1;
        state_d   = (ct_rddata == 8'd0) ? ST_IDLE : ST_RD_I;
      end
      ST_RD_I: begin
        i_d     = i_q + 8'd1;
        s_addr  = i_q + 8'd1;
        state_d = ST_RD_J;
      end
      ST_RD_J: begin
        si_d    = s_rddata;
        j_d     = j_q + s_rddata;
        s_addr  = j_q + s_rddata;
        state_d = ST_WR_I;
      end
      ST_WR_I: begin
        sj_d     = s_rddata;
        s_addr   = i_q;
        s_wrdata = s_rddata;
        s_wren   = 1'b1;
        state_d  = ST_WR_J;
      end
      ST_WR_J: begin
        s_addr   = j_q;
        s_wrdata = si_q;
        s_wren   = 1'b1;
        state_d  = ST_RD_K;
      end
      ST_RD_K: begin
        s_addr  = si_q + sj_q;
        ct_addr = k_q;
        state_d = ST_WR_PT;
      end
      ST_WR_PT: begin
        pt_addr   = k_q;
        pt_wrdata = s_rddata ^ ct_rddata;
        pt_wren   = 1'b1;
        if (k_q == len_q) begin
          state_d = ST_IDLE;
        end else begin
          k_d     = k_q + 8'd1;
          state_d = ST_RD_I;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign rdy = (state_q == ST_IDLE);

`ifdef ARC4_PRGA_ASCII_CHECK_EN
  logic ok_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_q <= 1'b1;
    end else if (rdy && en) begin
      ok_q <= 1'b1;
    end else if (state_q == ST_WR_PT && !is_print(pt_wrdata)) begin
      ok_q <= 1'b0;
    end
  end

  assign pt_ok = ok_q;
`endif

endmodule

// File: tb/tb_arc4_prga.sv
// Self-checking bench for arc4_prga: vector table plus PT-write scoreboard
// fed by an RC4 reference model, with reset and en-hold sequences.
module tb_arc4_prga;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr, s_rddata, s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr, ct_rddata;
  logic [7:0] pt_addr, pt_wrdata;
  logic       pt_wren;
`ifdef ARC4_PRGA_ASCII_CHECK_EN
  logic       pt_ok;
`endif

  always #5 clk = ~clk;

  arc4_prga dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .rdy       (rdy),
    .s_addr    (s_addr),
    .s_rddata  (s_rddata),
    .s_wrdata  (s_wrdata),
    .s_wren    (s_wren),
    .ct_addr   (ct_addr),
    .ct_rddata (ct_rddata),
    .pt_addr   (pt_addr),
    .pt_wrdata (pt_wrdata),
    .pt_wren   (pt_wren)
`ifdef ARC4_PRGA_ASCII_CHECK_EN
    ,
    .pt_ok     (pt_ok)
`endif
  );

  logic [7:0] s_mem  [256];
  logic [7:0] ct_mem [256];
  logic [7:0] pt_mem [256];
  logic       s_load = 1'b0;

  always @(posedge clk) begin
    if (s_load) begin
      for (int a = 0; a < 256; a++) s_mem[a] <= 8'(a);
    end else if (s_wren) begin
      s_mem[s_addr] <= s_wrdata;
    end
    s_rddata  <= s_mem[s_addr];
    ct_rddata <= ct_mem[ct_addr];
    if (pt_wren) pt_mem[pt_addr] <= pt_wrdata;
  end

  int errs = 0;
  int chks = 0;
  int s_wr_cnt = 0;
  logic [15:0] sbq [$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (s_wren) s_wr_cnt++;
      if (pt_wren) begin
        if (sbq.size() == 0) begin
          chk("pt_unexpected", {16'd0, pt_addr, pt_wrdata}, 32'hFFFF_FFFF);
        end else begin
          chk("pt_wr", {pt_addr, pt_wrdata}, sbq.pop_front());
        end
      end
    end
  end

  // Reference RC4 keystream on an identity S; pushes every PT write.
  task automatic model_push();
    logic [7:0] m [256];
    logic [7:0] i, j, t, tmp;
    int len;
    len = int'(ct_mem[0]);
    for (int a = 0; a < 256; a++) m[a] = 8'(a);
    i = 0;
    j = 0;
    sbq.push_back({8'd0, ct_mem[0]});
    for (int k = 1; k <= len; k++) begin
      i    = i + 8'd1;
      j    = j + m[i];
      tmp  = m[i];
      m[i] = m[j];
      m[j] = tmp;
      t    = m[i] + m[j];
      sbq.push_back({8'(k), m[t] ^ ct_mem[k]});
    end
  endtask

  task automatic load_s();
    @(negedge clk);
    s_load = 1'b1;
    @(negedge clk);
    s_load = 1'b0;
  endtask

  task automatic run(input bit hold, output int busy);
    model_push();
    s_wr_cnt = 0;
    load_s();
    chk("rdy_before", {31'd0, rdy}, 32'd1);
    en = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) en = 1'b0;
    busy = 0;
    while (busy < 2000) begin
      @(posedge clk);
      #1;
      busy++;
      if (rdy) break;
    end
    en = 1'b0;
    @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
  endtask

  typedef struct {
    logic [7:0]      len;
    logic [1:3][7:0] ct;
    logic [1:3][7:0] pt;
    int              busy;
    bit              hold;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int busy;
    int l;
    bit ok;
    vecs[0] = '{8'd1, {8'h00, 8'h00, 8'h00}, {8'h02, 8'h00, 8'h00}, 8, 1'b0};
    vecs[1] = '{8'd2, {8'h00, 8'h00, 8'h00}, {8'h02, 8'h05, 8'h00}, 14, 1'b0};
    vecs[2] = '{8'd0, {8'h00, 8'h00, 8'h00}, {8'h00, 8'h00, 8'h00}, 2, 1'b0};
    vecs[3] = '{8'd1, {8'h43, 8'h00, 8'h00}, {8'h41, 8'h00, 8'h00}, 8, 1'b1};
    vecs[4] = '{8'd1, {8'h02, 8'h00, 8'h00}, {8'h00, 8'h00, 8'h00}, 8, 1'b0};
    vecs[5] = '{8'd3, {8'h10, 8'h20, 8'h30}, {8'h12, 8'h25, 8'h37}, 20, 1'b0};

    for (int a = 0; a < 256; a++) ct_mem[a] = 8'h00;
    en    = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_rdy", {31'd0, rdy}, 32'd1);
    chk("rst_s_wren", {31'd0, s_wren}, 32'd0);
    chk("rst_pt_wren", {31'd0, pt_wren}, 32'd0);
    chk("rst_addrs", {8'd0, s_addr, ct_addr, pt_addr}, 32'd0);
`ifdef ARC4_PRGA_ASCII_CHECK_EN
    chk("rst_pt_ok", {31'd0, pt_ok}, 32'd1);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      ct_mem[0] = vecs[v].len;
      for (int k = 1; k <= 3; k++) ct_mem[k] = vecs[v].ct[k];
      run(vecs[v].hold, busy);
      chk($sformatf("busy_v%0d", v), busy, vecs[v].busy);
      chk($sformatf("pt0_v%0d", v), pt_mem[0], vecs[v].len);
      chk($sformatf("swr_v%0d", v), s_wr_cnt, 2 * int'(vecs[v].len));
      ok = 1'b1;
      for (int k = 1; k <= int'(vecs[v].len); k++) begin
        chk($sformatf("pt%0d_v%0d", k, v), pt_mem[k], vecs[v].pt[k]);
        if (vecs[v].pt[k] < 8'h20 || vecs[v].pt[k] > 8'h7E) ok = 1'b0;
      end
`ifdef ARC4_PRGA_ASCII_CHECK_EN
      chk($sformatf("pt_ok_v%0d", v), {31'd0, pt_ok}, {31'd0, ok});
`endif
      if (v == 0) begin
        chk("s1_v0", s_mem[1], 8'd1);
        chk("s2_v0", s_mem[2], 8'd2);
      end
      if (v == 1) begin
        chk("s2_v1", s_mem[2], 8'd3);
        chk("s3_v1", s_mem[3], 8'd2);
      end
    end

    // Asynchronous reset while the S swap writes are in flight.
    ct_mem[0] = 8'd3;
    sbq.push_back({8'd0, 8'd3});
    load_s();
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdy", {31'd0, rdy}, 32'd1);
    chk("mid_rst_s_wren", {31'd0, s_wren}, 32'd0);
    chk("mid_rst_pt_wren", {31'd0, pt_wren}, 32'd0);
    chk("mid_rst_s_addr", s_addr, 8'd0);
    chk("mid_rst_q", sbq.size(), 0);
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;

    ct_mem[0] = 8'd2;
    ct_mem[1] = 8'h00;
    ct_mem[2] = 8'h00;
    run(1'b0, busy);
    chk("post_rst_busy", busy, 14);
    chk("post_rst_pt2", pt_mem[2], 8'h05);

    l = $urandom_range(5, 30);
    ct_mem[0] = 8'(l);
    for (int k = 1; k <= l; k++) ct_mem[k] = 8'($urandom);
    run(1'b0, busy);
    chk("rand_busy", busy, 2 + 6 * l);

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end

endmodule
